// File: rtl/mlp_pkg.sv
// mlp_pkg: shared constants, fixed-point types and FSM states for the MLP classifier.
package mlp_pkg;
  localparam int N_IN  = 784;
  localparam int N_OUT = 10;
  localparam int FRAC  = 16;
  localparam int ACC_W = 48;
  typedef logic signed [31:0] q16_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef enum logic [2:0] {IDLE, L1, L1_WB, L2, L2_WB, DONE} state_t;
endpackage

// File: rtl/mlp_mac.sv
// mlp_mac: one Q16.16 MAC step (floor-shifted product into a 48-bit accumulator) plus sat32 narrowing.
// MLP_SATURATE_EN clamps sat32 to the signed 32-bit range; otherwise sat32 wraps to the low 32 bits.
module mlp_mac
  import mlp_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [31:0]      i_a,
  input  logic signed [31:0]      i_b,
  output logic signed [ACC_W-1:0] o_acc,
  output logic signed [31:0]      o_sat
);
  logic signed [63:0] w_prod;
  function automatic q16_t sat32(acc_t a);
`ifdef MLP_SATURATE_EN
    return (a > 48'sh00007FFFFFFF) ? 32'sh7FFFFFFF :
           (a < -48'sh000080000000) ? 32'sh80000000 : q16_t'(a);
`else
    return q16_t'(a);
`endif
  endfunction
  assign w_prod = 64'(i_a) * 64'(i_b);
  assign o_acc  = i_acc + acc_t'(w_prod >>> FRAC);
  assign o_sat  = sat32(i_acc);
endmodule

// File: rtl/mlp_classifier.sv
// mlp_classifier: free-running time-multiplexed 784->HIDDEN->10 Q16.16 perceptron, one MAC per clock.
module mlp_classifier
  import mlp_pkg::*;
#(
  parameter int    HIDDEN  = 32,
  parameter string W1_FILE = "w1.txt",
  parameter string B1_FILE = "b1.txt",
  parameter string W2_FILE = "w2.txt",
  parameter string B2_FILE = "b2.txt"
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic signed [31:0] image [0:N_IN-1],
  output logic signed [31:0] out   [0:N_OUT-1]
);
  localparam int JW  = HIDDEN > 1 ? $clog2(HIDDEN) : 1;
  localparam int W1W = $clog2(HIDDEN * N_IN);
  localparam int W2W = $clog2(N_OUT * HIDDEN);
  logic signed [31:0] r_w1 [0:HIDDEN*N_IN-1];
  logic signed [31:0] r_b1 [0:HIDDEN-1];
  logic signed [31:0] r_w2 [0:N_OUT*HIDDEN-1];
  logic signed [31:0] r_b2 [0:N_OUT-1];
  state_t r_state, w_next;
  logic [9:0]                r_i;
  logic [JW-1:0]             r_j;
  logic [3:0]                r_k;
  logic signed [ACC_W-1:0]   r_acc, w_mac;
  logic signed [31:0]        r_hidden   [0:HIDDEN-1];
  logic signed [31:0]        r_out_next [0:N_OUT-1];
  logic signed [31:0]        w_a, w_b, w_sat;
  logic [W1W-1:0]            w_w1_idx;
  logic [W2W-1:0]            w_w2_idx;
  logic                      w_i_last, w_j_last, w_k_last;
  assign w_i_last = r_i == 10'(N_IN - 1);
  assign w_j_last = r_j == JW'(HIDDEN - 1);
  assign w_k_last = r_k == 4'(N_OUT - 1);
  assign w_w1_idx = W1W'(int'(r_j) * N_IN + int'(r_i));
  assign w_w2_idx = W2W'(int'(r_k) * HIDDEN + int'(r_j));
  assign w_a = (r_state == L2) ? r_hidden[r_j] : image[r_i];
  assign w_b = (r_state == L2) ? r_w2[w_w2_idx] : r_w1[w_w1_idx];
  mlp_mac u_mac (
    .i_acc(r_acc),
    .i_a  (w_a),
    .i_b  (w_b),
    .o_acc(w_mac),
    .o_sat(w_sat)
  );
  always_ff @(posedge CLK or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = L1;
      L1:      w_next = w_i_last ? L1_WB : L1;
      L1_WB:   w_next = w_j_last ? L2 : L1;
      L2:      w_next = w_j_last ? L2_WB : L2;
      L2_WB:   w_next = w_k_last ? DONE : L2;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      for (int n = 0; n < HIDDEN; n++) r_hidden[n] <= '0;
      for (int n = 0; n < N_OUT; n++) begin
        r_out_next[n] <= '0;
        out[n]        <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_acc <= acc_t'(r_b1[0]);
          r_i   <= '0;
          r_j   <= '0;
          r_k   <= '0;
        end
        L1: begin
          r_acc <= w_mac;
          r_i   <= w_i_last ? '0 : r_i + 10'd1;
        end
        L1_WB: begin
          r_hidden[r_j] <= (w_sat < 0) ? '0 : w_sat;
          r_j   <= w_j_last ? '0 : r_j + JW'(1);
          r_k   <= '0;
          r_acc <= w_j_last ? acc_t'(r_b2[0]) : acc_t'(r_b1[r_j + JW'(1)]);
        end
        L2: begin
          r_acc <= w_mac;
          r_j   <= w_j_last ? '0 : r_j + JW'(1);
        end
        L2_WB: begin
          r_out_next[r_k] <= w_sat;
          r_k   <= r_k + 4'd1;
          r_acc <= w_k_last ? '0 : acc_t'(r_b2[r_k + 4'd1]);
        end
        default: out <= r_out_next;
      endcase
    end
endmodule

// File: tb/tb_mlp_classifier.sv
// tb_mlp_classifier: directed scoreboard bench; ROMs are loaded hierarchically while reset is held.
module tb_mlp_classifier;
  localparam int H   = 4;
  localparam int LAT = 2 + 785 * H + 10 * (H + 1);
  logic CLK = 1'b0;
  logic reset;
  logic signed [31:0] image [0:783];
  logic signed [31:0] out   [0:9];
  int checks = 0, errors = 0, done = 0, cnt = 0;
  bit rst_seen = 1'b0;
  logic [9:0][31:0] prev = '0;
  logic [9:0][31:0] q_v [$];
  string            q_n [$];

  always #5 CLK = ~CLK;

  mlp_classifier #(
    .HIDDEN(H), .W1_FILE(""), .B1_FILE(""), .W2_FILE(""), .B2_FILE("")
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .image(image),
    .out  (out)
  );

  task automatic chk(string nm, int k, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s out[%0d] got %h want %h", nm, k, a, e);
    end
  endtask

  // outputs must clear as soon as reset rises, before any clock edge
  always @(posedge reset) begin
    #1;
    for (int k = 0; k < 10; k++) chk("async_rst", k, out[k], 32'h0);
  end

  always @(negedge CLK) begin
    logic [9:0][31:0] v;
    string nm;
    if (reset) begin
      cnt = 0;
      prev = '0;
      if (!rst_seen) for (int k = 0; k < 10; k++) chk("reset", k, out[k], 32'h0);
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      cnt++;
      if (cnt == LAT - 1) for (int k = 0; k < 10; k++) chk("hold", k, out[k], prev[k]);
      if (cnt == LAT) begin
        if (q_v.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL update with no expectation queued");
        end else begin
          v  = q_v.pop_front();
          nm = q_n.pop_front();
          for (int k = 0; k < 10; k++) chk(nm, k, out[k], v[k]);
          prev = v;
        end
        done++;
      end
    end
  end

  task automatic fill(logic [31:0] img, logic [31:0] w1, logic [31:0] b1,
                      logic [31:0] w2, logic [31:0] b2);
    for (int i = 0; i < 784; i++) image[i] = img;
    for (int n = 0; n < H * 784; n++) dut.r_w1[n] = w1;
    for (int n = 0; n < H; n++) dut.r_b1[n] = b1;
    for (int n = 0; n < 10 * H; n++) dut.r_w2[n] = w2;
    for (int n = 0; n < 10; n++) dut.r_b2[n] = b2;
  endtask

  task automatic expect_out(string nm, logic [9:0][31:0] v);
    q_n.push_back(nm);
    q_v.push_back(v);
  endtask

  task automatic run(bit keep);
    int d0 = done;
    @(negedge CLK);
    #2 reset = 1'b0;
    for (int c = 0; c < LAT + 20 && done == d0; c++) @(negedge CLK);
    if (done == d0) begin
      checks++;
      errors++;
      $display("FAIL timeout no output update within %0d cycles", LAT + 20);
    end
    if (!keep) begin
      @(negedge CLK);
      #2 reset = 1'b1;
    end
  endtask

  initial begin
    logic [9:0][31:0] v;
    reset = 1'b1;
    fill(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    #100;
    fill(32'h0, 32'h00010000, 32'h0, 32'h00010000, 32'h0);
    for (int k = 0; k < 10; k++) begin
      dut.r_b2[k] = 32'(k << 16);
      v[k] = 32'(k << 16);
    end
    expect_out("bias2", v);
    run(1'b0);
    fill(32'h00010000, 32'h00010000, 32'h0, 32'h00010000, 32'h0);
    for (int k = 0; k < 10; k++) v[k] = 32'h0C400000;
    expect_out("ones", v);
    run(1'b0);
    fill(32'h0, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h00050000);
    for (int k = 0; k < 10; k++) v[k] = 32'h00050000;
    expect_out("relu", v);
    run(1'b0);
    fill(32'h00010000, 32'h7FFF0000, 32'h0, 32'h00010000, 32'h0);
`ifdef MLP_SATURATE_EN
    for (int k = 0; k < 10; k++) v[k] = 32'h7FFFFFFF;
`else
    for (int k = 0; k < 10; k++) v[k] = 32'h0;
`endif
    expect_out("sat_l1", v);
    run(1'b0);
    fill(32'h00010000, 32'h00010000, 32'h0, 32'h7FFF0000, 32'h0);
    for (int k = 0; k < 10; k++) begin
      dut.r_b2[k] = 32'(k << 16);
`ifdef MLP_SATURATE_EN
      v[k] = 32'h7FFFFFFF;
`else
      v[k] = 32'hF3C00000 + 32'(k << 16);
`endif
    end
    expect_out("sat_l2", v);
    run(1'b0);
    fill(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    image[5] = 32'h00020000;
    image[6] = 32'hFFFFFFFF;
    for (int j = 0; j < H; j++) begin
      dut.r_w1[j * 784 + 5] = 32'((j + 1) << 16);
      dut.r_w1[j * 784 + 6] = 32'h00008000;
      dut.r_b1[j] = 32'(j << 16);
    end
    for (int k = 0; k < 10; k++) begin
      dut.r_w2[k * H + (k % H)] = 32'h00010000;
      dut.r_b2[k] = 32'(k);
      v[k] = 32'((3 * (k % H) + 2) << 16) + 32'(k) - 32'd1;
    end
    expect_out("index", v);
    run(1'b1);
    repeat (1000) @(negedge CLK);
    #2 reset = 1'b1;
    repeat (10) @(negedge CLK);
    expect_out("rerun", v);
    run(1'b0);
    repeat (5) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
